jpeg_block_sequencer: RTL and testbench
=======================================

JPEG_BLOCK_SEQUENCER -- requirements
Module: jpeg_block_sequencer

Interface
REQ-001 SHALL have parameter DCT_LAT, default 4: dct_enable hold cycles, legal range 1..15.
REQ-002 SHALL have parameter QUANT_LAT, default 2: cycles per quantize row, legal range 1..7.
REQ-003 SHALL have parameter HUFF_TIMEOUT, default 1023: maximum HWAIT cycles before error.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports `clock` and `reset`.
REQ-005 SHALL have ports `clock` in 1 (system clock) and `reset` in 1 (async, active-high).
REQ-006 SHALL have ports `blk_valid` in 1 (source has a block) and `blk_ready` out 1 (sequencer accepts a block).
REQ-007 SHALL have ports `blk_lum` in 1 (luminance flag for the offered block) and `abort` in 1 (synchronous return to IDLE).
REQ-008 SHALL have port `huff_end` in 1: one-cycle end-of-block pulse from the Huffman controller.
REQ-009 SHALL have datapath-control outputs `input_enable`, `dct_enable`, `dct_end_enable`, `zigzag_input_enable`, `zigag_enable` and `Huffman_start`, each out 1.
REQ-010 SHALL have ports `matrix_row` out 8 (quantize/zigzag row select) and `is_luminance` out 1 (latched blk_lum).
REQ-011 SHALL have status ports `busy` out 1, `blk_done` out 1 (one-cycle pulse), `huff_err` out 1 (sticky) and `blk_count` out 16 (completed blocks).

Function
REQ-012 SHALL implement states IDLE, LOAD, DCT, DLATCH, QROW, ZZ, HSTART, HWAIT and DONE; all outputs SHALL be registered, Moore-decoded from the state.
REQ-013 SHALL behave in IDLE as follows: blk_ready=1 and busy=0; blk_valid=1 latches blk_lum into is_luminance and moves to LOAD.
REQ-014 SHALL hold LOAD for 1 cycle with input_enable=1, then move to DCT.
REQ-015 SHALL hold DCT for exactly DCT_LAT cycles with dct_enable=1, then move to DLATCH.
REQ-016 SHALL hold DLATCH for 1 cycle with dct_end_enable=1, then move to QROW with row=0.
REQ-017 SHALL, in QROW, drive matrix_row=row for QUANT_LAT cycles with zigzag_input_enable=1 only in the last of those cycles; the row then increments, and the state moves to ZZ after row 7.
REQ-018 SHALL hold ZZ for 1 cycle with zigag_enable=1, then move to HSTART.
REQ-019 SHALL hold HSTART for 1 cycle with Huffman_start=1, then move to HWAIT.
REQ-020 SHALL, in HWAIT, move to DONE on huff_end=1; a huff_end in any other state SHALL be ignored.
REQ-021 SHALL, in HWAIT, set huff_err=1 and move to DONE after HUFF_TIMEOUT cycles without huff_end.
REQ-022 SHALL hold DONE for 1 cycle with blk_done=1, increment blk_count (wrapping 0xFFFF->0x0000), then return to IDLE.
REQ-023 SHALL keep matrix_row at 0 outside QROW and keep busy=1 in every state except IDLE.
REQ-024 SHALL, on abort=1, go to IDLE on the next edge in any state, with no blk_done and blk_count unchanged; abort SHALL win over simultaneous huff_end, timeout or blk_valid.
REQ-025 SHALL clear huff_err only on reset or on an accepted block (IDLE to LOAD).
REQ-026 SHALL give, with default parameters and acceptance at edge 0: LOAD at cycle 1, DCT at cycles 2-5, DLATCH at 6, QROW at 7-22, ZZ at 23, HSTART at 24 and HWAIT from 25.

Reset
REQ-027 SHALL, on reset asserted, immediately set the state to IDLE; blk_ready=1; all enables, blk_done, busy, huff_err and is_luminance to 0; and matrix_row, blk_count and all counters to 0.
REQ-028 SHALL, when reset is asserted mid-block, produce no blk_done or Huffman_start pulse until a new block is accepted.

Structure
REQ-029 SHALL define the state enum, the parameter defaults and the row count 8 in shared package jpeg_seq_pkg.
REQ-030 SHALL instantiate one sub-module, jpeg_seq_timer: a loadable 10-bit down-counter with a zero flag, reused for the DCT, QROW and HWAIT timing.

Verification
REQ-031 SHALL cover nominal: blk_valid at cycle 0, huff_end at cycle 30 -> dct_enable high at cycles 2-5, zigzag_input_enable at 8,10,...,22 with matrix_row 0..7, Huffman_start at 24, blk_done at 31, blk_count=1.
REQ-032 SHALL cover timeout: HUFF_TIMEOUT=16 and no huff_end -> huff_err=1, blk_done 17 cycles after HWAIT entry, then IDLE.
REQ-033 SHALL cover abort: abort in QROW at row 3 -> IDLE next cycle, matrix_row=0, blk_count unchanged, no blk_done.
REQ-034 SHALL cover ignored end: huff_end pulsed during HSTART and then never again -> no exit from HWAIT before timeout.
REQ-035 SHALL cover back-to-back: blk_valid held high with blk_lum 1 then 0 -> second LOAD one cycle after the first DONE, is_luminance=0, blk_count=2.
REQ-036 SHALL cover async reset: reset at cycle 4 (DCT) -> dct_enable=0 with no clock edge, IDLE, and no Huffman_start afterwards.

Source files
------------

// File: rtl/jpeg_seq_pkg.sv
// jpeg_seq_pkg: shared state encoding, parameter defaults and block geometry for the JPEG block sequencer
package jpeg_seq_pkg;
  localparam int DCT_LAT_DEF = 4;
  localparam int QUANT_LAT_DEF = 2;
  localparam int HUFF_TIMEOUT_DEF = 1023;
  localparam int NUM_ROWS = 8;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DCT, S_DLATCH, S_QROW, S_ZZ, S_HSTART, S_HWAIT, S_DONE
  } state_t;
endpackage

// File: rtl/jpeg_seq_timer.sv
// jpeg_seq_timer: loadable 10-bit down-counter that saturates at zero
// Ports: clock/reset (async active-high), i_load/i_value load the count,
// o_count is the current count, o_zero flags a count of zero.
module jpeg_seq_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [9:0] i_value,
  output logic [9:0] o_count,
  output logic       o_zero
);
  logic [9:0] r_count;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (r_count != '0) r_count <= r_count - 10'd1;
  assign o_count = r_count;
  assign o_zero = r_count == '0;
endmodule

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: steps one 8x8 block through load, DCT, quantize/zigzag and Huffman phases
// Ports: clock/reset (async active-high); blk_valid/blk_ready/blk_lum block handshake;
// abort returns to IDLE; huff_end ends HWAIT; datapath enables, matrix_row and
// is_luminance drive the pipeline; busy/blk_done/huff_err/blk_count report status.
module jpeg_block_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int DCT_LAT = DCT_LAT_DEF,
  parameter int QUANT_LAT = QUANT_LAT_DEF,
  parameter int HUFF_TIMEOUT = HUFF_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        blk_lum,
  input  logic        abort,
  input  logic        huff_end,
  output logic        input_enable,
  output logic        dct_enable,
  output logic        dct_end_enable,
  output logic        zigzag_input_enable,
  output logic        zigag_enable,
  output logic        Huffman_start,
  output logic [7:0]  matrix_row,
  output logic        is_luminance,
  output logic        busy,
  output logic        blk_done,
  output logic        huff_err,
  output logic [15:0] blk_count
);
  state_t r_state, w_next;
  logic [2:0] r_row, w_row;
  logic w_load, w_zero, w_zero_next, w_timeout, w_accept;
  logic [9:0] w_load_val, w_count;

  jpeg_seq_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_count (w_count),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_next = r_state;
    w_row = r_row;
    w_load = 1'b0;
    w_load_val = '0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   w_next = blk_valid ? S_LOAD : S_IDLE;
      S_LOAD: begin
        w_next = S_DCT;
        w_load = 1'b1;
        w_load_val = 10'(DCT_LAT - 1);
      end
      S_DCT:    w_next = w_zero ? S_DLATCH : S_DCT;
      S_DLATCH: begin
        w_next = S_QROW;
        w_row = '0;
        w_load = 1'b1;
        w_load_val = 10'(QUANT_LAT - 1);
      end
      S_QROW:
        if (w_zero) begin
          if (r_row == 3'(NUM_ROWS - 1)) begin
            w_next = S_ZZ;
            w_row = '0;
          end else begin
            w_row = r_row + 3'd1;
            w_load = 1'b1;
            w_load_val = 10'(QUANT_LAT - 1);
          end
        end
      S_ZZ:     w_next = S_HSTART;
      S_HSTART: begin
        w_next = S_HWAIT;
        w_load = 1'b1;
        w_load_val = 10'(HUFF_TIMEOUT);
      end
      S_HWAIT:
        if (huff_end) w_next = S_DONE;
        else if (w_zero) begin
          w_next = S_DONE;
          w_timeout = 1'b1;
        end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
      w_row = '0;
      w_load = 1'b1;
      w_load_val = '0;
      w_timeout = 1'b0;
    end
  end

  assign w_accept = r_state == S_IDLE && w_next == S_LOAD;
  // outputs are registered from the next state, so the timer value seen in that
  // state must be predicted to flag the last cycle of each quantize row
  assign w_zero_next = w_load ? (w_load_val == '0) : (w_count <= 10'd1);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_row <= '0;
      blk_ready <= 1'b1;
      busy <= 1'b0;
      input_enable <= 1'b0;
      dct_enable <= 1'b0;
      dct_end_enable <= 1'b0;
      zigzag_input_enable <= 1'b0;
      zigag_enable <= 1'b0;
      Huffman_start <= 1'b0;
      blk_done <= 1'b0;
      matrix_row <= '0;
      is_luminance <= 1'b0;
      huff_err <= 1'b0;
      blk_count <= '0;
    end else begin
      r_state <= w_next;
      r_row <= w_row;
      blk_ready <= w_next == S_IDLE;
      busy <= w_next != S_IDLE;
      input_enable <= w_next == S_LOAD;
      dct_enable <= w_next == S_DCT;
      dct_end_enable <= w_next == S_DLATCH;
      zigzag_input_enable <= w_next == S_QROW && w_zero_next;
      zigag_enable <= w_next == S_ZZ;
      Huffman_start <= w_next == S_HSTART;
      blk_done <= w_next == S_DONE;
      matrix_row <= w_next == S_QROW ? 8'(w_row) : 8'd0;
      is_luminance <= w_accept ? blk_lum : is_luminance;
      huff_err <= w_accept ? 1'b0 : (huff_err | w_timeout);
      blk_count <= w_next == S_DONE ? blk_count + 16'd1 : blk_count;
    end
endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// tb_jpeg_block_sequencer: table-driven timeline with a scoreboard queue plus hand-written corner sequences
module tb_jpeg_block_sequencer;
  localparam int TO = 16;
  localparam logic [8:0] B_READY = 9'h100, B_BUSY = 9'h080, B_IE = 9'h040, B_DE = 9'h020,
                         B_DEE = 9'h010, B_ZIE = 9'h008, B_ZZE = 9'h004, B_HS = 9'h002, B_DONE = 9'h001;

  typedef struct {int lo; int hi; logic [8:0] ctl; logic [7:0] row;} seg_t;
  typedef struct {logic [34:0] v; int blk; int cyc;} sb_t;

  logic clock, reset, blk_valid, blk_ready, blk_lum, abort, huff_end;
  logic input_enable, dct_enable, dct_end_enable, zigzag_input_enable, zigag_enable, Huffman_start;
  logic [7:0] matrix_row;
  logic is_luminance, busy, blk_done, huff_err;
  logic [15:0] blk_count;
  logic [34:0] obs;

  seg_t segs[$];
  sb_t sb[$];
  int n_tests = 0, n_fail = 0, blk_id = 0;
  logic [15:0] cnt0 = '0;
  logic err0 = 1'b0, lum0 = 1'b0;

  jpeg_block_sequencer #(.HUFF_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_lum(blk_lum), .abort(abort), .huff_end(huff_end),
    .input_enable(input_enable), .dct_enable(dct_enable), .dct_end_enable(dct_end_enable),
    .zigzag_input_enable(zigzag_input_enable), .zigag_enable(zigag_enable),
    .Huffman_start(Huffman_start), .matrix_row(matrix_row), .is_luminance(is_luminance),
    .busy(busy), .blk_done(blk_done), .huff_err(huff_err), .blk_count(blk_count)
  );

  assign obs = {blk_count, huff_err, is_luminance, blk_ready, busy, input_enable, dct_enable,
                dct_end_enable, zigzag_input_enable, zigag_enable, Huffman_start, blk_done, matrix_row};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clock) begin : mon
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("blk%0d_cyc%0d", e.blk, e.cyc), 64'(obs), 64'(e.v));
    end
  end

  function automatic logic [34:0] idle_vec();
    return {cnt0, err0, lum0, B_READY, 8'd0};
  endfunction

  function automatic logic [34:0] exp_vec(int c, logic lum, int done, bit to, int ab_c);
    logic [8:0] ctl;
    logic [7:0] row;
    if (c > ab_c) return {cnt0, 1'b0, lum, B_READY, 8'd0};
    ctl = B_BUSY;
    row = 8'd0;
    foreach (segs[i]) if (c >= segs[i].lo && c <= segs[i].hi) begin
      ctl = segs[i].ctl;
      row = segs[i].row;
    end
    if (c == done) ctl = B_BUSY | B_DONE;
    return {(c >= done) ? 16'(cnt0 + 16'd1) : cnt0, (c == 0) ? err0 : (to && c >= done),
            (c == 0) ? lum0 : lum, ctl, row};
  endfunction

  // cycle 0 is the IDLE cycle in which the block is offered; end_c < 25 means no huff_end in HWAIT
  task automatic run_block(input logic lum, input int end_c, input int abort_c, input int last_c, input bit keep);
    int done;
    bit ab, to;
    to = end_c < 25;
    done = to ? 26 + TO : end_c + 1;
    ab = abort_c >= 0 && abort_c < done;
    blk_id++;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clock); #1;
      blk_valid = (c == 0) || keep;
      blk_lum = lum;
      huff_end = c == end_c;
      abort = c == abort_c;
      sb.push_back('{exp_vec(c, lum, done, to, ab ? abort_c : 1000000), blk_id, c});
    end
    if (!ab) begin
      cnt0 = cnt0 + 16'd1;
      err0 = to;
    end else err0 = 1'b0;
    lum0 = lum;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      blk_valid = 1'b0;
      huff_end = 1'b0;
      abort = 1'b0;
      sb.push_back('{idle_vec(), 0, c});
    end
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    blk_valid = 1'b0;
    blk_lum = 1'b0;
    abort = 1'b0;
    huff_end = 1'b0;
    segs.push_back('{0, 0, B_READY, 8'd0});
    segs.push_back('{1, 1, B_BUSY | B_IE, 8'd0});
    segs.push_back('{2, 5, B_BUSY | B_DE, 8'd0});
    segs.push_back('{6, 6, B_BUSY | B_DEE, 8'd0});
    for (int r = 0; r < 8; r++) begin
      segs.push_back('{7 + 2 * r, 7 + 2 * r, B_BUSY, 8'(r)});
      segs.push_back('{8 + 2 * r, 8 + 2 * r, B_BUSY | B_ZIE, 8'(r)});
    end
    segs.push_back('{23, 23, B_BUSY | B_ZZE, 8'd0});
    segs.push_back('{24, 24, B_BUSY | B_HS, 8'd0});
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 64'(obs), 64'(idle_vec()));
    reset = 1'b0;
    run_block(1'b1, 30, -1, 31, 1'b0);
    idle(2);
    run_block(1'b0, 24, -1, 26 + TO, 1'b0);
    idle(1);
    run_block(1'b1, -1, 13, 16, 1'b0);
    idle(1);
    run_block(1'b0, 30, 30, 33, 1'b0);
    @(posedge clock); #1;
    blk_valid = 1'b1;
    blk_lum = ~lum0;
    abort = 1'b1;
    sb.push_back('{idle_vec(), 99, 0});
    idle(2);
    run_block(1'b1, 30, -1, 31, 1'b1);
    run_block(1'b0, 30, -1, 31, 1'b0);
    idle(2);
    run_block(1'b1, -1, -1, 3, 1'b0);
    @(posedge clock); #1;
    blk_valid = 1'b0;
    chk("dct_before_reset", 64'(dct_enable), 64'd1);
    #1 reset = 1'b1;
    #1;
    cnt0 = '0;
    err0 = 1'b0;
    lum0 = 1'b0;
    chk("dct_async_clear", 64'(dct_enable), 64'd0);
    chk("async_reset_state", 64'(obs), 64'(idle_vec()));
    #1 reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (Huffman_start || blk_done || !blk_ready) bad = 1'b1;
    end
    chk("no_pulse_after_reset", 64'(bad), 64'd0);
    repeat (2) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
